axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read address/data channel between the instruction-cache refill path and the data-cache refill/uncached-read path.
- Sits between cache_soc's two miss engines and the top-level ar*/r* ports.
- Holds one outstanding read burst at a time, uses round-robin arbitration, and routes R beats back to the owner.
- Checks burst length with an internal beat counter.

Parameters:
- IID, 4'd0, arid driven for instruction-side bursts
- DID, 4'd1, arid driven for data-side bursts

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  icache read request; level, held until i_accept
- i_addr  in  32  icache burst physical address
- i_len  in  4  icache AXI arlen (beats-1)
- i_size  in  3  icache arsize
- i_cached  in  1  selects arcache 4'b1111 (1) or 4'b0000 (0)
- i_accept  out  1  one-cycle pulse: icache AR handshake completed
- i_rvalid  out  1  icache beat valid
- i_rdata  out  32  icache beat data
- i_rlast  out  1  icache last beat
- i_rerr  out  1  rresp!=OKAY on this beat
- d_req, d_addr, d_len, d_size, d_cached, d_accept, d_rvalid, d_rdata, d_rlast, d_rerr: data-side equivalents, same widths
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/4/3/2/2/4/3/1  AXI AR
- arready  in  1  AXI AR ready
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
- rready  out  1  AXI R ready
- proto_err  out  1  sticky: rlast disagreed with the beat count

Behaviour:
- Reset values:
  - state=IDLE; arvalid=0; rready=0; all *_accept, *_rvalid, *_rlast, *_rerr = 0.
  - proto_err=0; last-grant pointer = D, so I wins the first tie.
- Reset mid-burst drops the transaction silently; the AXI slave is reset by the same reset.
- Constant AR fields: arburst=2'b01, arlock=0, arprot=0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any req is high, grant one. With both requesting, grant the side not granted last (round-robin).
  - On grant, register owner, addr, len, size, cache, id into the AR registers; set arvalid=1; go to ADDR. Grant takes 1 cycle, with no combinational req-to-arvalid path.
  - Load beat counter = len.
- ADDR:
  - arvalid held with stable fields until arready.
  - On arvalid&&arready: pulse owner's *_accept for that same cycle; arvalid<=0, rready<=1; update last-grant; go to DATA.
  - The requester may drop req the cycle after accept.
- DATA:
  - rready=1 throughout; requesters cannot backpressure.
  - Each rvalid beat is forwarded combinationally to the owner only: owner_rvalid=rvalid, owner_rdata=rdata, owner_rlast=rlast, owner_rerr=(rresp!=2'b00). The other side's rvalid stays 0.
  - Beat counter decrements per beat.
  - On the rvalid&&rlast beat: rready<=0, go to IDLE. A new grant is possible on the next cycle (IDLE→ADDR), so back-to-back bursts have a 1-cycle AR bubble minimum.
  - proto_err is set if rlast arrives with counter!=0, or if a beat with counter==0 lacks rlast. In the latter case, continue until rlast.
  - rid is not used for routing. If rid!=registered arid, proto_err is set.
- A new req arriving during ADDR/DATA waits. A req from the current owner during DATA is treated as a new request after return to IDLE.
- Any rvalid seen in IDLE/ADDR is ignored (rready=0).

Test Plan:
- Single icache burst:
  - Stimulus: i_req, addr 0x1FC00000, len 7, cached=1; arready after 2 cycles.
  - Response: arid=0, arlen=7, arcache=4'hF, arburst=1; i_accept pulses once; 8 beats on i_rvalid with i_rlast on the 8th; d_rvalid never high.
- Simultaneous requests from reset:
  - Stimulus: i_req and d_req both high.
  - Response: I granted first, D second, then I again if both are still requesting; AR bursts alternate arid 0,1,0.
- Uncached data read:
  - Stimulus: d_req, addr 0x1FAF0000, len 0, size 2, cached=0.
  - Response: arcache=0, arid=1; one beat with d_rlast=1; state returns to IDLE next cycle.
- Error and protocol checks:
  - rresp=2'b10 on beat 3 of an 8-beat I burst → i_rerr=1 on that beat only.
  - rlast on beat 5 of len=7 → proto_err=1 and stays sticky; arbiter returns to IDLE.
- AR backpressure:
  - Stimulus: hold arready=0 for 10 cycles.
  - Response: arvalid and all AR fields stable; no accept pulse until the handshake.
- Reset mid-DATA:
  - Stimulus: assert reset after beat 2.
  - Response: next cycle arvalid=rready=0, all outputs zero; the next request is served normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between the icache and dcache
// refill engines. One burst in flight at a time, round-robin between the two
// sides, R beats steered back to whichever side owns the burst. A private beat
// counter cross-checks rlast and flags disagreement on the sticky proto_err.

// Per-side return path: accept pulse and R beat forwarding for one requester.
module axi_read_arbiter_route (
    input  logic        sel,
    input  logic        ar_fire,
    input  logic        r_fire,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rlast,
    input  logic [1:0]  bus_rresp,
    output logic        accept,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rerr
);
    assign accept = sel && ar_fire;
    assign rvalid = sel && r_fire;
    // Data is zeroed when not this side's beat so idle outputs read as zero.
    assign rdata  = rvalid ? bus_rdata : 32'h0;
    assign rlast  = rvalid && bus_rlast;
    assign rerr   = rvalid && (bus_rresp != 2'b00);
endmodule

module axi_read_arbiter #(
    parameter logic [3:0] IID = 4'd0,
    parameter logic [3:0] DID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction side
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_len,
    input  logic [2:0]  i_size,
    input  logic        i_cached,
    output logic        i_accept,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rerr,
    // data side
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_len,
    input  logic [2:0]  d_size,
    input  logic        d_cached,
    output logic        d_accept,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rerr,
    // AXI AR
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic        cached;
    } rd_req_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t  state;
    logic    owner;       // side holding the current burst
    logic    last_grant;  // side that most recently completed an AR handshake
    logic [3:0] beat_cnt; // beats remaining after the current one

    rd_req_t i_bus, d_bus, win;
    logic    grant_d;
    logic    ar_fire, r_fire;

    assign i_bus = {i_addr, i_len, i_size, i_cached};
    assign d_bus = {d_addr, d_len, d_size, d_cached};

    // Round-robin pick: on a tie the side not granted last wins.
    always_comb begin
        grant_d = 1'b0;
        if (i_req && d_req)
            grant_d = (last_grant == SIDE_I);
        else
            grant_d = d_req;
    end

    assign win = grant_d ? d_bus : i_bus;

    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arprot  = 3'b000;

    assign ar_fire = (state == ADDR) && arvalid && arready;
    assign r_fire  = (state == DATA) && rready && rvalid;

    // Arbitration / channel FSM; all AR and R control outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= SIDE_I;
            last_grant <= SIDE_D;
            beat_cnt   <= 4'd0;
            arid       <= 4'd0;
            araddr     <= 32'h0;
            arlen      <= 4'd0;
            arsize     <= 3'd0;
            arcache    <= 4'd0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner    <= grant_d;
                        arid     <= grant_d ? DID : IID;
                        araddr   <= win.addr;
                        arlen    <= win.len;
                        arsize   <= win.size;
                        arcache  <= win.cached ? 4'b1111 : 4'b0000;
                        beat_cnt <= win.len;
                        arvalid  <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (arvalid && arready) begin
                        arvalid    <= 1'b0;
                        rready     <= 1'b1;
                        last_grant <= owner;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (rready && rvalid) begin
                        if (rid != arid)
                            proto_err <= 1'b1;
                        if (rlast) begin
                            // Early rlast: still close the burst, just flag it.
                            if (beat_cnt != 4'd0)
                                proto_err <= 1'b1;
                            rready <= 1'b0;
                            state  <= IDLE;
                        end else if (beat_cnt == 4'd0) begin
                            // Overrun: keep draining until the slave sends rlast.
                            proto_err <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                end
            endcase
        end
    end

    // Return paths, index 0 = instruction side, 1 = data side.
    logic [1:0]       own_sel;
    logic [1:0]       side_accept, side_rvalid, side_rlast, side_rerr;
    logic [1:0][31:0] side_rdata;

    assign own_sel = {owner == SIDE_D, owner == SIDE_I};

    for (genvar g = 0; g < 2; g++) begin : g_route
        axi_read_arbiter_route u_route (
            .sel      (own_sel[g]),
            .ar_fire  (ar_fire),
            .r_fire   (r_fire),
            .bus_rdata(rdata),
            .bus_rlast(rlast),
            .bus_rresp(rresp),
            .accept   (side_accept[g]),
            .rvalid   (side_rvalid[g]),
            .rdata    (side_rdata[g]),
            .rlast    (side_rlast[g]),
            .rerr     (side_rerr[g])
        );
    end

    assign i_accept = side_accept[0];
    assign i_rvalid = side_rvalid[0];
    assign i_rdata  = side_rdata[0];
    assign i_rlast  = side_rlast[0];
    assign i_rerr   = side_rerr[0];

    assign d_accept = side_accept[1];
    assign d_rvalid = side_rvalid[1];
    assign d_rdata  = side_rdata[1];
    assign d_rlast  = side_rlast[1];
    assign d_rerr   = side_rerr[1];

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: the bench plays the AXI slave and both
// requesters, with expected values written out per scenario.
module tb_axi_read_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        i_req = 0, d_req = 0;
    logic [31:0] i_addr = 0, d_addr = 0;
    logic [3:0]  i_len = 0, d_len = 0;
    logic [2:0]  i_size = 0, d_size = 0;
    logic        i_cached = 0, d_cached = 0;
    logic        i_accept, i_rvalid, i_rlast, i_rerr;
    logic        d_accept, d_rvalid, d_rlast, d_rerr;
    logic [31:0] i_rdata, d_rdata;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid;
    logic        arready = 0;
    logic [3:0]  rid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0;
    logic        rlast = 0, rvalid = 0;
    logic        rready, proto_err;

    int total = 0;
    int bad = 0;

    axi_read_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_cached(i_cached),
        .i_accept(i_accept), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rerr(i_rerr),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size), .d_cached(d_cached),
        .d_accept(d_accept), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rerr(d_rerr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit side, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic c);
        if (!side) begin
            i_req = 1; i_addr = a; i_len = l; i_size = s; i_cached = c;
        end else begin
            d_req = 1; d_addr = a; d_len = l; d_size = s; d_cached = c;
        end
    endtask

    task automatic apply_reset();
        reset = 1; i_req = 0; d_req = 0; arready = 0; rvalid = 0; rlast = 0; rresp = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_state", {arvalid, rready, proto_err, i_accept, d_accept, i_rvalid, d_rvalid,
                          i_rlast, d_rlast, i_rerr, d_rerr}, 0);
    endtask

    // Wait for AR, hold it off for 'stall' cycles, then complete the handshake.
    task automatic ar_phase(input bit side, input logic [31:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic c, input int stall, input bit drop);
        int n = 0;
        logic [46:0] fexp;
        fexp = {(side ? 4'd1 : 4'd0), a, l, s, (c ? 4'hF : 4'h0)};
        while (arvalid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ar_wait", arvalid, 1);
        chk("ar_fields", {arid, araddr, arlen, arsize, arcache}, fexp);
        chk("ar_const", {arburst, arlock, arprot}, 7'b01_00_000);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("ar_hold_v", arvalid, 1);
            chk("ar_hold_f", {arid, araddr, arlen, arsize, arcache}, fexp);
            chk("ar_no_acc", {i_accept, d_accept}, 0);
        end
        arready = 1;
        @(negedge clk);
        chk("acc_pulse", {d_accept, i_accept}, side ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        arready = 0;
        if (drop) begin
            if (side) d_req = 0; else i_req = 0;
        end
        chk("ar_done", {arvalid, rready}, 2'b01);
        chk("acc_once", {i_accept, d_accept}, 0);
    endtask

    // Drive nb beats; rlast on beat last_at (0 = never), rresp=SLVERR on err_at.
    task automatic r_phase(input bit side, input int nb, input int last_at, input int err_at,
                           input logic [3:0] rid_v);
        logic [31:0] dv;
        for (int b = 1; b <= nb; b++) begin
            dv = 32'hA500_0000 + 32'(nb * 256 + b);
            rvalid = 1; rid = rid_v; rdata = dv;
            rlast = (b == last_at);
            rresp = (b == err_at) ? 2'b10 : 2'b00;
            @(negedge clk);
            if (!side) begin
                chk("i_rvalid", i_rvalid, 1);
                chk("i_rdata", i_rdata, dv);
                chk("i_rlast", i_rlast, b == last_at);
                chk("i_rerr", i_rerr, b == err_at);
                chk("d_quiet", d_rvalid, 0);
            end else begin
                chk("d_rvalid", d_rvalid, 1);
                chk("d_rdata", d_rdata, dv);
                chk("d_rlast", d_rlast, b == last_at);
                chk("d_rerr", d_rerr, b == err_at);
                chk("i_quiet", i_rvalid, 0);
            end
            @(posedge clk); #1;
        end
        rvalid = 0; rlast = 0; rresp = 0;
        chk("r_end_rready", rready, (last_at != 0) ? 1'b0 : 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_state", {arvalid, rready, proto_err, i_accept, d_accept, i_rvalid, d_rvalid,
                          i_rlast, d_rlast, i_rerr, d_rerr}, 0);

        // single icache burst, arready after 2 cycles
        set_req(0, 32'h1FC0_0000, 4'd7, 3'd2, 1'b1);
        #1 chk("no_comb_ar", arvalid, 0);
        ar_phase(0, 32'h1FC0_0000, 4'd7, 3'd2, 1'b1, 2, 1);
        r_phase(0, 8, 8, 0, 4'd0);
        chk("t1_perr", proto_err, 0);

        // simultaneous requests from reset: I, D, I
        apply_reset();
        set_req(0, 32'h0000_1000, 4'd3, 3'd2, 1'b1);
        set_req(1, 32'h0000_2000, 4'd1, 3'd2, 1'b1);
        ar_phase(0, 32'h0000_1000, 4'd3, 3'd2, 1'b1, 0, 0);
        r_phase(0, 4, 4, 0, 4'd0);
        ar_phase(1, 32'h0000_2000, 4'd1, 3'd2, 1'b1, 0, 0);
        r_phase(1, 2, 2, 0, 4'd1);
        ar_phase(0, 32'h0000_1000, 4'd3, 3'd2, 1'b1, 0, 1);
        d_req = 0;
        r_phase(0, 4, 4, 0, 4'd0);

        // uncached single-beat data read
        set_req(1, 32'h1FAF_0000, 4'd0, 3'd2, 1'b0);
        ar_phase(1, 32'h1FAF_0000, 4'd0, 3'd2, 1'b0, 0, 1);
        r_phase(1, 1, 1, 0, 4'd1);
        chk("t3_idle", {arvalid, rready}, 0);

        // SLVERR on beat 3 only
        set_req(0, 32'h1FC0_0100, 4'd7, 3'd2, 1'b1);
        ar_phase(0, 32'h1FC0_0100, 4'd7, 3'd2, 1'b1, 0, 1);
        r_phase(0, 8, 8, 3, 4'd0);
        chk("t4_perr", proto_err, 0);

        // early rlast on beat 5 of 8
        set_req(0, 32'h1FC0_0200, 4'd7, 3'd2, 1'b1);
        ar_phase(0, 32'h1FC0_0200, 4'd7, 3'd2, 1'b1, 0, 1);
        r_phase(0, 5, 5, 0, 4'd0);
        chk("early_rlast_perr", proto_err, 1);

        // AR backpressure for 10 cycles; proto_err stays sticky
        set_req(1, 32'h1FAF_0040, 4'd3, 3'd2, 1'b1);
        ar_phase(1, 32'h1FAF_0040, 4'd3, 3'd2, 1'b1, 10, 1);
        r_phase(1, 4, 4, 0, 4'd1);
        chk("perr_sticky", proto_err, 1);

        // reset after beat 2 of an 8-beat burst
        apply_reset();
        set_req(0, 32'h1FC0_0300, 4'd7, 3'd2, 1'b1);
        ar_phase(0, 32'h1FC0_0300, 4'd7, 3'd2, 1'b1, 0, 1);
        r_phase(0, 2, 0, 0, 4'd0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        rvalid = 1; rlast = 1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("midrst_out", {arvalid, rready, proto_err, i_rvalid, d_rvalid, i_rlast, i_rerr}, 0);
        chk("midrst_data", i_rdata, 0);
        rvalid = 0; rlast = 0;
        @(posedge clk); #1;
        set_req(1, 32'h0000_3000, 4'd1, 3'd2, 1'b1);
        ar_phase(1, 32'h0000_3000, 4'd1, 3'd2, 1'b1, 0, 1);
        r_phase(1, 2, 2, 0, 4'd1);
        chk("post_rst_perr", proto_err, 0);

        // overrun: len=1 but rlast only on beat 3
        set_req(0, 32'h0000_0040, 4'd1, 3'd2, 1'b1);
        ar_phase(0, 32'h0000_0040, 4'd1, 3'd2, 1'b1, 0, 1);
        r_phase(0, 3, 3, 0, 4'd0);
        chk("overrun_perr", proto_err, 1);

        // rid mismatch on a data-side burst
        apply_reset();
        set_req(1, 32'h0000_0080, 4'd0, 3'd2, 1'b1);
        ar_phase(1, 32'h0000_0080, 4'd0, 3'd2, 1'b1, 0, 1);
        r_phase(1, 1, 1, 0, 4'd0);
        chk("rid_perr", proto_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
